// File: rtl/da_dct_engine_if.sv
// Handshake, sample, result and table-load signals of one DA DCT coefficient engine.
// master = producer/consumer side, slave = engine side.
interface da_dct_engine_if #(
  parameter int N_TAPS = 4,
  parameter int IN_W   = 12,
  parameter int COEF_W = 12,
  parameter int OUT_W  = 12
);
  logic                     in_valid;
  logic                     in_ready;
  logic [N_TAPS*IN_W-1:0]   in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_W-1:0]         out_data;
  logic                     out_sat;
  logic                     tbl_we;
  logic [N_TAPS-1:0]        tbl_addr;
  logic [COEF_W-1:0]        tbl_wdata;

  modport master (
    output in_valid, in_data, out_ready, tbl_we, tbl_addr, tbl_wdata,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready, tbl_we, tbl_addr, tbl_wdata,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/da_dct_engine.sv
// Distributed-arithmetic inner product y = sum(c_i * x_i) over N_TAPS signed samples,
// LANES bit-slices per cycle, loadable partial-sum table, round-half-up and saturation.
module da_dct_engine #(
  parameter int N_TAPS  = 4,
  parameter int IN_W    = 12,
  parameter int COEF_W  = 12,
  parameter int LANES   = 4,
  parameter int OUT_W   = 12,
  parameter int FRAC_SH = 10
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  da_dct_engine_if.slave  bus
);
  localparam int STEPS = IN_W / LANES;
  localparam int ACC_W = COEF_W + STEPS + 1;
  localparam int SUM_W = COEF_W + IN_W + 1;
  localparam int S_W   = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [S_W-1:0] S_LAST = S_W'(STEPS - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCUM   = 2'd1;
  localparam logic [1:0] COMBINE = 2'd2;
  localparam logic [1:0] OUT     = 2'd3;

  localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] OUT_MIN = SUM_W'(-(2 ** (OUT_W - 1)));
  localparam logic signed [SUM_W-1:0] HALF    = SUM_W'(2 ** (FRAC_SH - 1));

  logic [1:0]                 state;
  logic [S_W-1:0]             s;
  logic [N_TAPS*IN_W-1:0]     x_reg;
  logic signed [COEF_W-1:0]   tbl      [2**N_TAPS];
  logic signed [ACC_W-1:0]    acc      [LANES];
  logic signed [ACC_W-1:0]    acc_next [LANES];
  logic signed [SUM_W-1:0]    part     [LANES+1];
  logic signed [SUM_W-1:0]    rnd;
  logic [OUT_W-1:0]           res;
  logic                       res_sat;
  logic                       accept;

  assign bus.in_ready = !sys_rst && ((state == IDLE) || ((state == OUT) && bus.out_ready));
  assign accept       = bus.in_valid && bus.in_ready;

  assign part[0] = '0;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    int unsigned              bit_idx;
    logic [N_TAPS-1:0]        addr;
    logic signed [ACC_W-1:0]  t_ext;

    // Lane l walks its own STEPS-bit slice of every sample, MSB first.
    assign bit_idx = l * STEPS + (STEPS - 1) - 32'(s);

    // addr bit (N_TAPS-1-i) belongs to sample x_i, which sits in field N_TAPS-1-i.
    for (genvar j = 0; j < N_TAPS; j++) begin : g_tap
      logic [IN_W-1:0] samp;
      assign samp    = x_reg[j*IN_W +: IN_W];
      assign addr[j] = |(samp & (IN_W'(1) << bit_idx));
    end

    assign t_ext = ACC_W'(tbl[addr]);

    // Only the sample sign bit carries negative weight.
    if (l == LANES - 1) begin : g_sign
      assign acc_next[l] = (s == '0) ? (acc[l] <<< 1) - t_ext : (acc[l] <<< 1) + t_ext;
    end else begin : g_plain
      assign acc_next[l] = (acc[l] <<< 1) + t_ext;
    end

    assign part[l+1] = part[l] + (SUM_W'(acc[l]) <<< (l * STEPS));
  end

  always_comb begin
    rnd     = (part[LANES] + HALF) >>> FRAC_SH;
    res     = rnd[OUT_W-1:0];
    res_sat = 1'b0;
    if (rnd > OUT_MAX) begin
      res     = OUT_MAX[OUT_W-1:0];
      res_sat = 1'b1;
    end else if (rnd < OUT_MIN) begin
      res     = OUT_MIN[OUT_W-1:0];
      res_sat = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= IDLE;
      s             <= '0;
      x_reg         <= '0;
      acc           <= '{default: '0};
      tbl           <= '{default: '0};
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
    end else begin
      // Table is writable only while idle so an in-flight vector never sees a change.
      if (bus.tbl_we && (state == IDLE))
        tbl[bus.tbl_addr] <= bus.tbl_wdata;

      if (accept) begin
        state <= ACCUM;
        s     <= '0;
        x_reg <= bus.in_data;
        acc   <= '{default: '0};
      end

      case (state)
        ACCUM: begin
          acc <= acc_next;
          if (s == S_LAST) state <= COMBINE;
          else             s     <= s + 1'b1;
        end
        COMBINE: begin
          bus.out_data  <= res;
          bus.out_sat   <= res_sat;
          bus.out_valid <= 1'b1;
          state         <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (!accept) state <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
